// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one outstanding word request at a time,
// and buffers returned instructions with their PCs in a small FIFO for decode.
module instr_fetch_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             mem_req_valid,
  output logic [WIDTH-1:0] mem_req_addr,
  input  logic             mem_req_ready,
  input  logic             mem_rsp_valid,
  input  logic [31:0]      mem_rsp_data,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             dec_ready
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_M  = {{(WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   fetch_pc, fetch_pc_next;
  logic [WIDTH-1:0]   req_pc, req_pc_next;
  logic [CNT_W-1:0]   count, count_next;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_next;
  logic               req_valid, req_valid_next;
  logic               hs, push, pop, flush;
  logic [31:0]        fifo_data [DEPTH];
  logic [WIDTH-1:0]   fifo_pc   [DEPTH];

  assign hs            = req_valid & mem_req_ready;
  assign mem_req_valid = req_valid;
  assign mem_req_addr  = fetch_pc;
  assign instr_valid   = (count != {CNT_W{1'b0}});
  assign instr         = fifo_data[rd_ptr];
  assign instr_pc      = fifo_pc[rd_ptr];

  // Next-state, fetch PC and FIFO bookkeeping; redirect overrides everything else.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_pc_next   = req_pc;
    push          = 1'b0;
    pop           = 1'b0;
    flush         = 1'b0;
    if (redirect) begin
      flush         = 1'b1;
      fetch_pc_next = redirect_pc & ALIGN_M;
      case (state)
        ST_REQ:  state_next = hs ? ST_DROP : ST_REQ;
        // A response arriving with the redirect is the stale one; it is discarded right here.
        ST_WAIT: state_next = mem_rsp_valid ? ST_REQ : ST_DROP;
        ST_DROP: state_next = mem_rsp_valid ? ST_REQ : ST_DROP;
        default: state_next = ST_REQ;
      endcase
    end else begin
      pop = instr_valid & dec_ready;
      case (state)
        ST_REQ: begin
          if (hs) begin
            req_pc_next   = fetch_pc;
            fetch_pc_next = fetch_pc + PC_STEP;
            state_next    = ST_WAIT;
          end else begin
            state_next    = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            push       = 1'b1;
            state_next = ST_REQ;
          end else begin
            state_next = ST_WAIT;
          end
        end
        ST_DROP: state_next = mem_rsp_valid ? ST_REQ : ST_DROP;
        default: state_next = ST_REQ;
      endcase
    end

    if (flush) begin
      count_next  = {CNT_W{1'b0}};
      wr_ptr_next = {PTR_W{1'b0}};
      rd_ptr_next = {PTR_W{1'b0}};
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
      wr_ptr_next = push ? wr_ptr + PTR_W'(1) : wr_ptr;
      rd_ptr_next = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    end

    // Request valid is registered so it stays low while reset is held.
    req_valid_next = (state_next == ST_REQ) && (count_next < DEPTH_C);
  end

  // Control and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_REQ;
      fetch_pc  <= RESET_PC & ALIGN_M;
      req_pc    <= {WIDTH{1'b0}};
      count     <= {CNT_W{1'b0}};
      wr_ptr    <= {PTR_W{1'b0}};
      rd_ptr    <= {PTR_W{1'b0}};
      req_valid <= 1'b0;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      req_pc    <= req_pc_next;
      count     <= count_next;
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      req_valid <= req_valid_next;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= 32'h0;
        fifo_pc[i]   <= {WIDTH{1'b0}};
      end
    end else if (push) begin
      fifo_data[wr_ptr] <= mem_rsp_data;
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a small memory responder with configurable latency,
// request/pop logs, and hand-computed expected addresses, PCs and instruction words.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        dec_ready;

  always #5 clk = ~clk;

  instr_fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .dec_ready(dec_ready)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] req_log [64];
  logic [31:0] pop_pc  [64];
  logic [31:0] pop_ins [64];
  int          n_req, n_pop;
  int          rsp_lat;
  bit          pend;
  int          pend_left;
  logic [31:0] pend_addr;

  // Memory image: upper half a fixed tag, lower half the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: log handshakes and pops seen before the edge, then drive the memory response.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    hs = mem_req_valid && mem_req_ready;
    a  = mem_req_addr;
    if (hs && n_req < 64) begin
      req_log[n_req] = a;
      n_req++;
    end
    if (instr_valid && dec_ready && !redirect && !rst && n_pop < 64) begin
      pop_pc[n_pop]  = instr_pc;
      pop_ins[n_pop] = instr;
      n_pop++;
    end
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    if (hs) begin
      pend      = 1'b1;
      pend_left = rsp_lat;
      pend_addr = a;
    end
    if (pend) begin
      pend_left--;
      if (pend_left == 0) begin
        pend          = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_word(pend_addr);
      end
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    redirect      = 1'b0;
    mem_rsp_valid = 1'b0;
    pend          = 1'b0;
    repeat (2) tick();
    rst   = 1'b0;
    n_req = 0;
    n_pop = 0;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0; dec_ready = 1'b1;
    rsp_lat = 1; pend = 1'b0; pend_left = 0; pend_addr = 32'h0; n_req = 0; n_pop = 0;

    // 1: reset values, then streaming fetch with 1-cycle memory
    tick(); tick();
    check_eq("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
    check_eq("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_instr_pc", instr_pc, 32'h0);
    rst = 1'b0; n_req = 0; n_pop = 0;
    tick();
    check_eq("first_addr", mem_req_addr, 32'h0);
    check_eq("first_valid", {31'b0, mem_req_valid}, 32'h1);
    repeat (11) tick();
    check_eq("t1_req0", req_log[0], 32'h0);
    check_eq("t1_req1", req_log[1], 32'h4);
    check_eq("t1_req2", req_log[2], 32'h8);
    check_eq("t1_pc0", pop_pc[0], 32'h0);
    check_eq("t1_pc1", pop_pc[1], 32'h4);
    check_eq("t1_pc2", pop_pc[2], 32'h8);
    check_eq("t1_ins0", pop_ins[0], 32'hA5A5_0000);
    check_eq("t1_ins2", pop_ins[2], 32'hA5A5_0008);

    // 2: decode stalled -> exactly DEPTH requests, then drain and resume at 0x10
    dec_ready = 1'b0;
    do_reset();
    repeat (20) tick();
    check_eq("t2_nreq", 32'(n_req), 32'd4);
    check_eq("t2_full_req_valid", {31'b0, mem_req_valid}, 32'h0);
    check_eq("t2_head_valid", {31'b0, instr_valid}, 32'h1);
    check_eq("t2_head_pc", instr_pc, 32'h0);
    dec_ready = 1'b1;
    repeat (16) tick();
    check_eq("t2_pc0", pop_pc[0], 32'h0);
    check_eq("t2_pc1", pop_pc[1], 32'h4);
    check_eq("t2_pc2", pop_pc[2], 32'h8);
    check_eq("t2_pc3", pop_pc[3], 32'hC);
    check_eq("t2_pc4", pop_pc[4], 32'h10);
    check_eq("t2_ins4", pop_ins[4], 32'hA5A5_0010);
    check_eq("t2_req4", req_log[4], 32'h10);

    // 3: redirect while waiting on a slow response
    rsp_lat = 3;
    do_reset();
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    check_eq("t3_flush_empty", {31'b0, instr_valid}, 32'h0);
    check_eq("t3_drop_no_req", {31'b0, mem_req_valid}, 32'h0);
    tick(); tick();
    check_eq("t3_req_valid", {31'b0, mem_req_valid}, 32'h1);
    check_eq("t3_req_addr", mem_req_addr, 32'h100);
    rsp_lat = 1; n_pop = 0;
    repeat (6) tick();
    check_eq("t3_pc0", pop_pc[0], 32'h100);
    check_eq("t3_ins0", pop_ins[0], 32'hA5A5_0100);
    check_eq("t3_pc1", pop_pc[1], 32'h104);

    // 4a: redirect in the same cycle as the request handshake
    do_reset();
    tick();
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    check_eq("t4_drop_no_req", {31'b0, mem_req_valid}, 32'h0);
    tick();
    check_eq("t4_req_valid", {31'b0, mem_req_valid}, 32'h1);
    check_eq("t4_req_addr", mem_req_addr, 32'h200);
    n_pop = 0;
    repeat (8) tick();
    check_eq("t4_pc0", pop_pc[0], 32'h200);
    check_eq("t4_ins0", pop_ins[0], 32'hA5A5_0200);

    // 4b: redirect coinciding with a pop from a full FIFO
    dec_ready = 1'b0;
    repeat (20) tick();
    check_eq("t4b_full_no_req", {31'b0, mem_req_valid}, 32'h0);
    check_eq("t4b_full_valid", {31'b0, instr_valid}, 32'h1);
    dec_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    check_eq("t4b_cleared", {31'b0, instr_valid}, 32'h0);
    check_eq("t4b_req_valid", {31'b0, mem_req_valid}, 32'h1);
    check_eq("t4b_req_addr", mem_req_addr, 32'h300);
    n_pop = 0;
    repeat (6) tick();
    check_eq("t4b_pc0", pop_pc[0], 32'h300);

    // 5: top-of-address-space wrap with memory back-pressure
    mem_req_ready = 1'b0;
    do_reset();
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0; n_req = 0; n_pop = 0;
    for (int i = 0; i < 5; i++) begin
      check_eq("t5_hold_addr", mem_req_addr, 32'hFFFF_FFFC);
      check_eq("t5_hold_valid", {31'b0, mem_req_valid}, 32'h1);
      tick();
    end
    mem_req_ready = 1'b1;
    repeat (10) tick();
    check_eq("t5_req0", req_log[0], 32'hFFFF_FFFC);
    check_eq("t5_req1", req_log[1], 32'h0);
    check_eq("t5_pc0", pop_pc[0], 32'hFFFF_FFFC);
    check_eq("t5_ins0", pop_ins[0], 32'hA5A5_FFFC);
    check_eq("t5_pc1", pop_pc[1], 32'h0);

    // 6: reset asserted while a request is outstanding
    dec_ready = 1'b0; rsp_lat = 3;
    do_reset();
    repeat (5) tick();
    check_eq("t6_pre_valid", {31'b0, instr_valid}, 32'h1);
    tick();
    rst = 1'b1;
    #1;
    check_eq("t6_rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("t6_rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
    check_eq("t6_rst_instr_pc", instr_pc, 32'h0);
    check_eq("t6_rst_instr", instr, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check_eq("t6_no_late_push", {31'b0, instr_valid}, 32'h0);
    check_eq("t6_req_valid", {31'b0, mem_req_valid}, 32'h1);
    check_eq("t6_req_addr", mem_req_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
